// File: rtl/cga_hdmi_seq.sv
// rtl/cga_hdmi_seq.sv - CGA-to-HDMI frame-lock sequencer gating video until line count is stable
// Optional hsync watchdog is built in when CGA_HDMI_SEQ_WATCHDOG_EN is defined.

module cga_hdmi_seq #(
    parameter int SETTLE_FRAMES = 2,
    parameter int HS_TIMEOUT    = 2047
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] video_in,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [3:0] video_out,
    output logic       de_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       locked,
    output logic [9:0] lines_per_frame
);
    typedef enum logic [1:0] {BLANK = 2'd0, SETTLE = 2'd1, ACTIVE = 2'd2} state_t;

    localparam logic [3:0] SETTLE_TARGET = 4'(SETTLE_FRAMES);
    localparam logic [9:0] LINE_MAX      = 10'd1023;

    state_t     state, state_next;
    logic       hs_prev, vs_prev;
    logic       hs_rise, vs_rise, expire, active_now;
    logic [9:0] line_cnt, line_cnt_next;
    logic [9:0] prev_lines, prev_lines_next;
    logic [9:0] lpf_next;
    logic [3:0] settle_cnt, settle_cnt_next;

    assign hs_rise    = hsync_in & ~hs_prev;
    assign vs_rise    = vsync_in & ~vs_prev;
    assign active_now = (state == ACTIVE);
    assign locked     = active_now;

`ifdef CGA_HDMI_SEQ_WATCHDOG_EN
    localparam logic [10:0] HS_LIMIT = 11'(HS_TIMEOUT);
    logic [10:0] hs_timer;

    // Timer parks at the limit so a lost hsync expires exactly once.
    assign expire = !hs_rise && (hs_timer + 11'd1 == HS_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hs_timer <= '0;
        else if (hs_rise)
            hs_timer <= '0;
        else if (hs_timer != HS_LIMIT)
            hs_timer <= hs_timer + 11'd1;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        prev_lines_next = prev_lines;
        lpf_next        = lines_per_frame;
        line_cnt_next   = line_cnt;
        if (hs_rise && line_cnt != LINE_MAX)
            line_cnt_next = line_cnt + 10'd1;

        if (expire) begin
            state_next = BLANK;
        end else if (vs_rise) begin
            // An hsync coinciding with vsync is line 1 of the new frame.
            line_cnt_next = {9'd0, hs_rise};
            case (state)
                BLANK: begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                    prev_lines_next = '0;
                end
                SETTLE: begin
                    prev_lines_next = line_cnt;
                    lpf_next        = line_cnt;
                    if (line_cnt == prev_lines) begin
                        settle_cnt_next = settle_cnt + 4'd1;
                        if (settle_cnt + 4'd1 >= SETTLE_TARGET)
                            state_next = ACTIVE;
                    end else begin
                        settle_cnt_next = '0;
                    end
                end
                ACTIVE: begin
                    lpf_next = line_cnt;
                    if (line_cnt != prev_lines) begin
                        state_next      = SETTLE;
                        settle_cnt_next = '0;
                        prev_lines_next = line_cnt;
                    end
                end
                default: state_next = BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= BLANK;
            hs_prev         <= 1'b0;
            vs_prev         <= 1'b0;
            line_cnt        <= '0;
            settle_cnt      <= '0;
            prev_lines      <= '0;
            lines_per_frame <= '0;
            video_out       <= 4'h0;
            de_out          <= 1'b0;
            hsync_out       <= 1'b0;
            vsync_out       <= 1'b0;
        end else begin
            state           <= state_next;
            hs_prev         <= hsync_in;
            vs_prev         <= vsync_in;
            line_cnt        <= line_cnt_next;
            settle_cnt      <= settle_cnt_next;
            prev_lines      <= prev_lines_next;
            lines_per_frame <= lpf_next;
            // Gate with the state in force while the pixel is sampled.
            de_out          <= de_in & active_now;
            video_out       <= (de_in && active_now) ? video_in : 4'h0;
            hsync_out       <= hsync_in;
            vsync_out       <= vsync_in;
        end
    end
endmodule
